// File: rtl/lsu_stage_if.sv
// lsu_stage_if -- bundles every lsu_stage signal except clk/rst.
//   slave  : view taken by lsu_stage itself
//   master : view taken by the surrounding pipeline / bus environment
interface lsu_stage_if;

  // execute-stage bundle
  logic        s_valid;
  logic        s_ready;
  logic        mvalidX;
  logic        mwenX;
  logic [7:0]  mwmaskX;
  logic [2:0]  mrtypeX;
  logic [31:0] addrX;
  logic [31:0] wdataX;
  logic [31:0] resultX;
  logic [4:0]  rdX;

  // memory bus request channel
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_addr;
  logic        bus_wen;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;

  // memory bus response channel
  logic        bus_resp_valid;
  logic [31:0] bus_rdata;
  logic        bus_resp_err;

  // writeback bundle
  logic        m_valid;
  logic        m_ready;
  logic [31:0] wbdataM;
  logic [4:0]  rdM;
  logic        faultM;

  modport slave (
    input  s_valid, mvalidX, mwenX, mwmaskX, mrtypeX, addrX, wdataX, resultX, rdX,
    output s_ready,
    output bus_req_valid, bus_addr, bus_wen, bus_wdata, bus_wstrb,
    input  bus_req_ready,
    input  bus_resp_valid, bus_rdata, bus_resp_err,
    output m_valid, wbdataM, rdM, faultM,
    input  m_ready
  );

  modport master (
    output s_valid, mvalidX, mwenX, mwmaskX, mrtypeX, addrX, wdataX, resultX, rdX,
    input  s_ready,
    input  bus_req_valid, bus_addr, bus_wen, bus_wdata, bus_wstrb,
    output bus_req_ready,
    output bus_resp_valid, bus_rdata, bus_resp_err,
    input  m_valid, wbdataM, rdM, faultM,
    output m_ready
  );

endinterface

// File: rtl/lsu_stage.sv
// lsu_stage -- single-outstanding load/store unit between execute and writeback.
// One bundle at a time walks IDLE -> (REQ -> WAIT_RESP ->) DONE -> IDLE.
// Non-memory bundles skip the bus and return resultX one cycle after accept.
// Optional feature macro: LSU_ACCESS_FAULT_EN
//   defined   : bus_resp_err and misaligned half/word accesses raise faultM
//   undefined : faultM is always 0, bus_resp_err ignored, no alignment check
// Store width is inferred from the byte mask: 4'b0011 = halfword, 4'b1111 = word.
module lsu_stage (
  input  logic       clk,
  input  logic       rst,
  lsu_stage_if.slave lsu_if
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] REQ       = 2'd1;
  localparam logic [1:0] WAIT_RESP = 2'd2;
  localparam logic [1:0] DONE      = 2'd3;

  localparam logic [2:0] RT_LB  = 3'd0;
  localparam logic [2:0] RT_LH  = 3'd1;
  localparam logic [2:0] RT_LW  = 3'd2;
  localparam logic [2:0] RT_LBU = 3'd4;
  localparam logic [2:0] RT_LHU = 3'd5;

  logic [1:0]  state;

  // bundle fields kept for the response phase
  logic [1:0]  byte_off_q;
  logic [2:0]  mrtype_q;
  logic        wen_q;
  logic [31:0] result_q;

  logic        accept;
  logic [1:0]  in_off;
  logic [31:0] shifted_rdata;
  logic [31:0] load_data;
  logic        misaligned;
  logic        resp_fault;
  logic        unused_bits;

  assign lsu_if.s_ready       = (state == IDLE);
  assign lsu_if.m_valid       = (state == DONE);
  assign lsu_if.bus_req_valid = (state == REQ);

  assign accept = lsu_if.s_valid && (state == IDLE);
  assign in_off = lsu_if.addrX[1:0];

  // Align the returned word to the accessed byte and extend per load type.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    shifted_rdata = lsu_if.bus_rdata >> {byte_off_q, 3'b000};
    load_data     = shifted_rdata;
    case (mrtype_q)
      RT_LB:   load_data = {{24{shifted_rdata[7]}}, shifted_rdata[7:0]};
      RT_LH:   load_data = {{16{shifted_rdata[15]}}, shifted_rdata[15:0]};
      RT_LW:   load_data = shifted_rdata;
      RT_LBU:  load_data = {24'd0, shifted_rdata[7:0]};
      RT_LHU:  load_data = {16'd0, shifted_rdata[15:0]};
      default: load_data = shifted_rdata;
    endcase
  end

`ifdef LSU_ACCESS_FAULT_EN
  // Flag half/word accesses whose address is not naturally aligned.
  always_comb begin
    misaligned = 1'b0;
    if (lsu_if.mvalidX) begin
      if (lsu_if.mwenX) begin
        if (lsu_if.mwmaskX[3:0] == 4'b0011)      misaligned = in_off[0];
        else if (lsu_if.mwmaskX[3:0] == 4'b1111) misaligned = (in_off != 2'd0);
      end else begin
        case (lsu_if.mrtypeX)
          RT_LH, RT_LHU: misaligned = in_off[0];
          RT_LW:         misaligned = (in_off != 2'd0);
          default:       misaligned = 1'b0;
        endcase
      end
    end
  end

  assign resp_fault  = lsu_if.bus_resp_err;
  assign unused_bits = &{1'b0, lsu_if.mwmaskX[7:4]};
`else
  assign misaligned  = 1'b0;
  assign resp_fault  = 1'b0;
  assign unused_bits = &{1'b0, lsu_if.mwmaskX[7:4], lsu_if.bus_resp_err};
`endif

  // Handshake FSM plus registered bus-request and writeback fields.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the datapath registers are reset too, because their values are
      // visible on the bus and writeback ports straight out of reset.
      state          <= IDLE;
      byte_off_q     <= 2'd0;
      mrtype_q       <= 3'd0;
      wen_q          <= 1'b0;
      result_q       <= 32'd0;
      lsu_if.bus_addr  <= 32'd0;
      lsu_if.bus_wen   <= 1'b0;
      lsu_if.bus_wdata <= 32'd0;
      lsu_if.bus_wstrb <= 4'd0;
      lsu_if.wbdataM   <= 32'd0;
      lsu_if.rdM       <= 5'd0;
      lsu_if.faultM    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            byte_off_q <= in_off;
            mrtype_q   <= lsu_if.mrtypeX;
            wen_q      <= lsu_if.mwenX;
            result_q   <= lsu_if.resultX;
            lsu_if.rdM <= lsu_if.rdX;
            if (lsu_if.mvalidX && misaligned) begin
              // faulting access never reaches the bus
              state          <= DONE;
              lsu_if.wbdataM <= 32'd0;
              lsu_if.faultM  <= 1'b1;
            end else if (lsu_if.mvalidX) begin
              state            <= REQ;
              lsu_if.bus_addr  <= {lsu_if.addrX[31:2], 2'b00};
              lsu_if.bus_wen   <= lsu_if.mwenX;
              lsu_if.bus_wdata <= lsu_if.wdataX << {in_off, 3'b000};
              lsu_if.bus_wstrb <= lsu_if.mwmaskX[3:0] << in_off;
            end else begin
              state          <= DONE;
              lsu_if.wbdataM <= lsu_if.resultX;
              lsu_if.faultM  <= 1'b0;
            end
          end
        end

        REQ: begin
          // request fields are only written in IDLE, so they hold here
          if (lsu_if.bus_req_ready) state <= WAIT_RESP;
        end

        WAIT_RESP: begin
          if (lsu_if.bus_resp_valid) begin
            state <= DONE;
            if (resp_fault) begin
              lsu_if.wbdataM <= 32'd0;
              lsu_if.faultM  <= 1'b1;
            end else begin
              lsu_if.wbdataM <= wen_q ? result_q : load_data;
              lsu_if.faultM  <= 1'b0;
            end
          end
        end

        DONE: begin
          // the IDLE cycle that follows is the mandatory bubble
          if (lsu_if.m_ready) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage -- scoreboard bench for lsu_stage: directed corner cases, then
// randomized bundles against a high-level load/store reference model.
`timescale 1ns/1ps
module tb_lsu_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_stage_if lif();

  lsu_stage dut (
    .clk    (clk),
    .rst    (rst),
    .lsu_if (lif)
  );

`ifdef LSU_ACCESS_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  typedef struct packed { logic [31:0] wbdata; logic [4:0] rd; logic fault; } out_t;
  typedef struct packed { logic [31:0] addr; logic wen; logic [31:0] wdata; logic [3:0] wstrb; } req_t;
  typedef struct packed { logic [31:0] rdata; logic err; } rsp_t;

  out_t exp_q[$];
  req_t req_q[$];
  rsp_t rsp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int hs_count = 0;

  // environment knobs: -1 = random, 0/1 = forced
  int ready_force    = 0;
  int mready_force   = 0;
  int resp_delay_max = 0;
  bit resp_enable    = 1'b1;
  bit stray_en       = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] load_model(input logic [31:0] rdata, input int off, input int rt);
    longint unsigned div = 1;
    longint unsigned w, b;
    repeat (off) div = div * 256;
    w = rdata / div;
    case (rt)
      0: begin b = w % 256;   return (b >= 128)   ? 32'(b + 64'hFFFFFF00) : 32'(b); end
      1: begin b = w % 65536; return (b >= 32768) ? 32'(b + 64'hFFFF0000) : 32'(b); end
      4: return 32'(w % 256);
      5: return 32'(w % 65536);
      default: return 32'(w);
    endcase
  endfunction

  function automatic bit misaligned_model(input bit wen, input int mask4, input int rt, input int off);
    bit half, word;
    half = wen ? (mask4 == 3)  : (rt == 1 || rt == 5);
    word = wen ? (mask4 == 15) : (rt == 2);
    return FAULT_EN && ((half && (off % 2 == 1)) || (word && off != 0));
  endfunction

  function automatic req_t req_model(input logic [31:0] addr, input bit wen,
                                     input logic [31:0] wdata, input int mask4);
    req_t r;
    int off;
    longint unsigned mult = 1;
    off = int'(addr % 4);
    repeat (off) mult = mult * 256;
    r.addr  = addr - 32'(off);
    r.wen   = wen;
    r.wdata = 32'((longint'(wdata) * mult) % 64'h1_0000_0000);
    r.wstrb = 4'((mask4 * (1 << off)) % 16);
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic issue(input bit mem, input bit wen, input logic [7:0] mask, input logic [2:0] rt,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] result,
                       input logic [31:0] rdata, input logic [4:0] rd, input bit err, input bit track);
    out_t o;
    int   off, budget;
    off     = int'(addr % 4);
    o.rd    = rd;
    o.fault = 1'b0;
    if (!mem) begin
      o.wbdata = result;
    end else if (misaligned_model(wen, int'(mask % 16), int'(rt), off)) begin
      o.wbdata = 32'd0;
      o.fault  = 1'b1;
    end else begin
      req_q.push_back(req_model(addr, wen, wdata, int'(mask % 16)));
      rsp_q.push_back({rdata, err});
      if (FAULT_EN && err) begin
        o.wbdata = 32'd0;
        o.fault  = 1'b1;
      end else begin
        o.wbdata = wen ? result : load_model(rdata, off, int'(rt));
      end
    end
    if (track) exp_q.push_back(o);

    lif.mvalidX = mem;   lif.mwenX  = wen;   lif.mwmaskX = mask; lif.mrtypeX = rt;
    lif.addrX   = addr;  lif.wdataX = wdata; lif.resultX = result; lif.rdX   = rd;
    lif.s_valid = 1'b1;
    budget = 0;
    forever begin
      @(negedge clk);
      if (lif.s_ready) break;
      budget++;
      if (budget > 200) begin
        check("accept_timeout", lif.s_ready, 1);
        break;
      end
    end
    @(posedge clk); #1;
    lif.s_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int budget = 0;
    forever begin
      @(negedge clk);
      if (lif.m_valid && lif.m_ready) break;
      budget++;
      if (budget > 200) begin
        check(name, lif.m_valid, 1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // ---------------- bus responder ----------------
  initial begin : bus_model
    int   wait_cnt;
    bit   hs;
    rsp_t r;
    wait_cnt = -1;
    r = '0;
    lif.bus_req_ready  = 1'b0;
    lif.bus_resp_valid = 1'b0;
    lif.bus_rdata      = 32'd0;
    lif.bus_resp_err   = 1'b0;
    forever begin
      @(negedge clk);
      hs = lif.bus_req_valid && lif.bus_req_ready && !rst;
      @(posedge clk); #1;
      lif.bus_resp_valid = 1'b0;
      lif.bus_rdata      = $urandom;
      lif.bus_resp_err   = 1'($urandom_range(0, 1));
      if (hs) begin
        r = (rsp_q.size() > 0) ? rsp_q.pop_front() : '0;
        wait_cnt = resp_enable ? int'($urandom_range(0, resp_delay_max)) : -1;
      end else if (wait_cnt > 0) begin
        wait_cnt--;
      end
      lif.bus_req_ready = (ready_force >= 0) ? ready_force[0] : 1'($urandom_range(0, 1));
      if (wait_cnt == 0) begin
        lif.bus_resp_valid = 1'b1;
        lif.bus_rdata      = r.rdata;
        lif.bus_resp_err   = r.err;
        wait_cnt = -1;
      end else if (wait_cnt < 0 && stray_en) begin
        // no response outstanding: noise the DUT must ignore
        lif.bus_resp_valid = ($urandom_range(0, 3) == 0);
      end
    end
  end

  initial begin : mready_drv
    lif.m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      lif.m_ready = (mready_force >= 0) ? mready_force[0] : 1'($urandom_range(0, 1));
    end
  end

  // ---------------- monitors ----------------
  initial begin : req_monitor
    req_t held, cur, e;
    bit   pending = 1'b0;
    forever begin
      @(negedge clk);
      cur = {lif.bus_addr, lif.bus_wen, lif.bus_wdata, lif.bus_wstrb};
      if (pending && lif.bus_req_valid) begin
        check("req_addr_stable",  cur.addr,  held.addr);
        check("req_wdata_stable", cur.wdata, held.wdata);
        check("req_ctl_stable",   {cur.wen, cur.wstrb}, {held.wen, held.wstrb});
      end
      pending = 1'b0;
      if (lif.bus_req_valid && !rst) begin
        if (lif.bus_req_ready) begin
          hs_count++;
          if (req_q.size() == 0) begin
            check("req_unexpected", lif.bus_req_valid, 0);
          end else begin
            e = req_q.pop_front();
            check("req_addr",  cur.addr,  e.addr);
            check("req_wdata", cur.wdata, e.wdata);
            check("req_wen",   cur.wen,   e.wen);
            check("req_wstrb", cur.wstrb, e.wstrb);
          end
        end else begin
          held    = cur;
          pending = 1'b1;
        end
      end
    end
  end

  initial begin : out_monitor
    out_t held, cur, e;
    bit   pending = 1'b0;
    forever begin
      @(negedge clk);
      cur = {lif.wbdataM, lif.rdM, lif.faultM};
      if (lif.m_valid) begin
        check("s_ready_in_done", lif.s_ready, 0);
        if (pending) begin
          check("wb_stable",  cur.wbdata, held.wbdata);
          check("rd_stable",  {cur.rd, cur.fault}, {held.rd, held.fault});
        end
        if (lif.m_ready) begin
          pending = 1'b0;
          if (exp_q.size() == 0) begin
            check("out_unexpected", lif.m_valid, 0);
          end else begin
            e = exp_q.pop_front();
            check("wbdataM", cur.wbdata, e.wbdata);
            check("rdM",     cur.rd,     e.rd);
            check("faultM",  cur.fault,  e.fault);
          end
        end else begin
          held    = cur;
          pending = 1'b1;
        end
      end else begin
        pending = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin : stimulus
    int h0, budget;
    lif.s_valid = 1'b0; lif.mvalidX = 1'b0; lif.mwenX  = 1'b0; lif.mwmaskX = 8'd0;
    lif.mrtypeX = 3'd0; lif.addrX   = 32'd0; lif.wdataX = 32'd0; lif.resultX = 32'd0;
    lif.rdX     = 5'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready",   lif.s_ready, 1);
    check("rst_m_valid",   lif.m_valid, 0);
    check("rst_req_valid", lif.bus_req_valid, 0);
    check("rst_wbdataM",   lif.wbdataM, 0);
    check("rst_rdM",       lif.rdM, 0);
    check("rst_faultM",    lif.faultM, 0);
    check("rst_bus_addr",  lif.bus_addr, 0);
    check("rst_bus_wdata", lif.bus_wdata, 0);
    check("rst_bus_ctl",   {lif.bus_wen, lif.bus_wstrb}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ready_force = 1; mready_force = 1; resp_delay_max = 0;
    @(posedge clk); #1;

    // non-memory bundle: one-cycle latency, then a bubble
    issue(0, 0, 8'h00, 3'd0, 32'h0, 32'h0, 32'h1234, 32'h0, 5'd5, 0, 1);
    @(negedge clk);
    check("alu_m_valid",   lif.m_valid, 1);
    check("alu_wbdataM",   lif.wbdataM, 32'h1234);
    check("alu_rdM",       lif.rdM, 5);
    check("alu_no_req",    lif.bus_req_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("alu_bubble_s_ready", lif.s_ready, 1);
    @(posedge clk); #1;

    // lb / lbu at byte 3, zero-wait bus: three-cycle latency
    issue(1, 0, 8'h01, 3'd0, 32'h8000_0003, 32'h0, 32'h0, 32'h80FF_FFFF, 5'd7, 0, 1);
    @(negedge clk);
    check("lb_req_valid", lif.bus_req_valid, 1);
    check("lb_bus_addr",  lif.bus_addr, 32'h8000_0000);
    check("lb_lat1",      lif.m_valid, 0);
    @(negedge clk);
    check("lb_lat2",      lif.m_valid, 0);
    @(negedge clk);
    check("lb_lat3",      lif.m_valid, 1);
    check("lb_wbdataM",   lif.wbdataM, 32'hFFFF_FF80);
    @(posedge clk); #1;
    issue(1, 0, 8'h01, 3'd4, 32'h8000_0003, 32'h0, 32'h0, 32'h80FF_FFFF, 5'd8, 0, 1);
    wait_done("lbu_timeout");

    // sh at halfword offset 2
    issue(1, 1, 8'h03, 3'd1, 32'h8000_0002, 32'h0000_ABCD, 32'h55, 32'h0, 5'd9, 0, 1);
    @(negedge clk);
    check("sh_bus_wstrb", lif.bus_wstrb, 4'hC);
    check("sh_bus_wdata", lif.bus_wdata, 32'hABCD_0000);
    check("sh_bus_addr",  lif.bus_addr, 32'h8000_0000);
    check("sh_bus_wen",   lif.bus_wen, 1);
    wait_done("sh_timeout");

    // bus_req_ready low for four cycles, then high: one handshake, stable fields
    ready_force = 0;
    h0 = hs_count;
    issue(1, 1, 8'h0F, 3'd2, 32'h1000_0010, 32'h1357_9BDF, 32'h77, 32'h0, 5'd10, 0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_req_valid", lif.bus_req_valid, 1);
      check("stall_bus_addr",  lif.bus_addr, 32'h1000_0010);
      check("stall_bus_wdata", lif.bus_wdata, 32'h1357_9BDF);
      check("stall_bus_wstrb", lif.bus_wstrb, 4'hF);
      if (i == 3) ready_force = 1;
    end
    wait_done("stall_timeout");
    check("stall_single_hs", hs_count - h0, 1);

    // m_ready low for three cycles in DONE
    mready_force = 0;
    issue(0, 0, 8'h00, 3'd0, 32'h0, 32'h0, 32'hCAFE_F00D, 32'h0, 5'd9, 0, 1);
    repeat (3) begin
      @(negedge clk);
      check("hold_m_valid", lif.m_valid, 1);
      check("hold_s_ready", lif.s_ready, 0);
      check("hold_wbdataM", lif.wbdataM, 32'hCAFE_F00D);
      check("hold_rdM",     lif.rdM, 9);
    end
    mready_force = 1;
    wait_done("hold_timeout");

    // reset while waiting for the response, then a stray response in IDLE
    resp_enable = 1'b0;
    issue(1, 0, 8'h0F, 3'd2, 32'h0000_2000, 32'h0, 32'h0, 32'h0, 5'd3, 0, 0);
    @(negedge clk);
    check("rstwait_req_valid", lif.bus_req_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    lif.bus_resp_valid = 1'b1;
    lif.bus_rdata      = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rstwait_s_ready", lif.s_ready, 1);
    check("rstwait_m_valid", lif.m_valid, 0);
    check("rstwait_wbdataM", lif.wbdataM, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("stray_m_valid",   lif.m_valid, 0);
    check("stray_s_ready",   lif.s_ready, 1);
    check("stray_req_valid", lif.bus_req_valid, 0);
    resp_enable = 1'b1;
    @(posedge clk); #1;

`ifdef LSU_ACCESS_FAULT_EN
    // misaligned lw skips the bus and faults after one cycle
    h0 = hs_count;
    issue(1, 0, 8'h0F, 3'd2, 32'h8000_0001, 32'h0, 32'h0, 32'h0, 5'd4, 0, 1);
    @(negedge clk);
    check("mis_m_valid",   lif.m_valid, 1);
    check("mis_faultM",    lif.faultM, 1);
    check("mis_req_valid", lif.bus_req_valid, 0);
    @(posedge clk); #1;
    check("mis_no_hs", hs_count - h0, 0);
    // bus error on an aligned lw
    issue(1, 0, 8'h0F, 3'd2, 32'h8000_0004, 32'h0, 32'h0, 32'h1234_5678, 5'd6, 1, 1);
    wait_done("err_timeout");
`endif

    // randomized traffic
    ready_force = -1; mready_force = -1; resp_delay_max = 3; stray_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic [7:0] mask;
      case ($urandom_range(0, 3))
        0:       mask = 8'h01;
        1:       mask = 8'h03;
        2:       mask = 8'h0F;
        default: mask = 8'($urandom);
      endcase
      issue(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), mask,
            3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom,
            5'($urandom), 1'($urandom_range(0, 3) == 0), 1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    budget = 0;
    while (exp_q.size() != 0 && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    check("drain_outputs",  exp_q.size(), 0);
    check("drain_requests", req_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
